prbs_checker: RTL and testbench

- Receive end of the LFSR noise link: takes the serial bit stream produced by the 16-bit maximal-length noise generator (its noise[0] tap) and self-synchronises to it.
- Verifies every following bit against a local prediction, counts mismatches and declares or loses lock.
- Used for on-chip link and bring-up BIST between the noise source and any consumer path.

---
 rtl/prbs_pkg.sv | 32 +++
 rtl/prbs_checker.sv | 135 +++++++++++++
 tb/tb_prbs_checker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS noise link: checker state encoding, LFSR tap
// positions and the feedback function used by both generator and checker.
package prbs_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_state_e;

  // Widest register the feedback helper accepts; narrower shadows are zero-extended.
  localparam int LFSR_MAX_W = 64;

  // Tap positions expressed as offsets below the register width (W-1, W-3, W-4, W-6).
  localparam int TAP_A_OFS = 1;
  localparam int TAP_B_OFS = 3;
  localparam int TAP_C_OFS = 4;
  localparam int TAP_D_OFS = 6;

  // XOR of the four taps of a width-bit register held in the low bits of shadow.
  function automatic logic lfsr_feedback(input logic [LFSR_MAX_W-1:0] shadow,
                                         input int                    width);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      if (i == width - TAP_A_OFS || i == width - TAP_B_OFS ||
          i == width - TAP_C_OFS || i == width - TAP_D_OFS)
        fb = fb ^ shadow[i];
    end
    return fb;
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for a nonzero seed, then free-runs its
// own LFSR and compares each received bit, tracking errors and loss of lock.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LFSR_WIDTH    = 16,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int BIT_CNT_WIDTH = 32,
  parameter int WINDOW        = 64,
  parameter int LOSS_THRESH   = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  input  logic                     bit_in,
  input  logic                     clear_in,
  output logic                     locked_out,
  output logic                     err_out,
  output logic [ERR_CNT_WIDTH-1:0] err_count_out,
  output logic [BIT_CNT_WIDTH-1:0] bit_count_out
);

  localparam int FILL_W = $clog2(LFSR_WIDTH);
  localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  prbs_state_e               state, state_nxt;
  logic [LFSR_WIDTH-1:0]     shadow, shadow_nxt;
  logic [FILL_W-1:0]         fill_cnt, fill_nxt;
  logic [WIN_W-1:0]          win_cnt, win_cnt_nxt;
  logic [WERR_W-1:0]         win_err, win_err_nxt;
  logic                      err_q, err_nxt;
  logic [ERR_CNT_WIDTH-1:0]  err_cnt, err_cnt_nxt;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt, bit_cnt_nxt;

  logic                      expected, mismatch;
  logic [LFSR_WIDTH-1:0]     hunt_shift;
  logic [WERR_W-1:0]         win_next;

  // Prediction of the next stream bit from the local shadow register.
  always_comb begin
    expected   = lfsr_feedback(LFSR_MAX_W'(shadow), LFSR_WIDTH);
    mismatch   = bit_in ^ expected;
    hunt_shift = {shadow[LFSR_WIDTH-2:0], bit_in};
    win_next   = win_err + WERR_W'(mismatch);
  end

  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    fill_nxt    = fill_cnt;
    win_cnt_nxt = win_cnt;
    win_err_nxt = win_err;
    err_nxt     = 1'b0;
    err_cnt_nxt = err_cnt;
    bit_cnt_nxt = bit_cnt;

    if (valid_in) begin
      unique case (state)
        HUNT: begin
          shadow_nxt = hunt_shift;
          if (fill_cnt == FILL_W'(LFSR_WIDTH - 1)) begin
            fill_nxt = '0;
            // All-zero is the LFSR lock-up value: refill rather than lock on it.
            if (|hunt_shift) begin
              state_nxt   = LOCKED;
              win_cnt_nxt = '0;
              win_err_nxt = '0;
            end
          end else begin
            fill_nxt = fill_cnt + 1'b1;
          end
        end

        LOCKED: begin
          // Shift in the prediction so a corrupted bit cannot poison later checks.
          shadow_nxt = {shadow[LFSR_WIDTH-2:0], expected};
          err_nxt    = mismatch;
          if (bit_cnt != '1)
            bit_cnt_nxt = bit_cnt + 1'b1;
          if (mismatch && err_cnt != '1)
            err_cnt_nxt = err_cnt + 1'b1;

          if (win_next >= WERR_W'(LOSS_THRESH)) begin
            state_nxt   = HUNT;
            fill_nxt    = '0;
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt + 1'b1;
            win_err_nxt = win_next;
          end
        end

        default: state_nxt = HUNT;
      endcase
    end

    if (clear_in) begin
      err_cnt_nxt = '0;
      bit_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= HUNT;
      shadow   <= '0;
      fill_cnt <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
      err_q    <= 1'b0;
      err_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      shadow   <= shadow_nxt;
      fill_cnt <= fill_nxt;
      win_cnt  <= win_cnt_nxt;
      win_err  <= win_err_nxt;
      err_q    <= err_nxt;
      err_cnt  <= err_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
    end
  end

  assign locked_out    = (state == LOCKED);
  assign err_out       = err_q;
  assign err_count_out = err_cnt;
  assign bit_count_out = bit_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: drives a 16-bit Fibonacci noise generator
// stream with planted bit flips and checks lock, error and counter behaviour.
module tb_prbs_checker;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        bit_in;
  logic        clear_in;
  logic        locked_out;
  logic        err_out;
  logic [15:0] err_count_out;
  logic [31:0] bit_count_out;

  logic [15:0] gen;
  int          nchk = 0;
  int          nerr = 0;
  int          err_pulses = 0;

  always #5 clk_in = ~clk_in;

  prbs_checker dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_in      (valid_in),
    .bit_in        (bit_in),
    .clear_in      (clear_in),
    .locked_out    (locked_out),
    .err_out       (err_out),
    .err_count_out (err_count_out),
    .bit_count_out (bit_count_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic v, input logic b, input logic c);
    valid_in = v;
    bit_in   = b;
    clear_in = c;
    @(posedge clk_in);
    #1;
    if (err_out) err_pulses++;
  endtask

  // Next generator bit (taps 15,13,12,10), optionally inverted.
  task automatic send(input logic flip, input logic clr);
    gen = {gen[14:0], gen[15] ^ gen[13] ^ gen[12] ^ gen[10]};
    step(1'b1, gen[0] ^ flip, clr);
  endtask

  task automatic send_n(input int n);
    repeat (n) send(1'b0, 1'b0);
  endtask

  initial begin
    rst_in   = 1'b0;
    valid_in = 1'b0;
    bit_in   = 1'b0;
    clear_in = 1'b0;
    gen      = 16'hFFFF;
    #12;
    chk("rst_locked", locked_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_ecnt", err_count_out, 0);
    chk("rst_bcnt", bit_count_out, 0);
    rst_in = 1'b1;

    // Clean lock and 1000 clean bits
    send_n(15);
    chk("lock_15", locked_out, 0);
    send_n(1);
    chk("lock_16", locked_out, 1);
    chk("lock_bcnt0", bit_count_out, 0);
    send_n(1000);
    chk("clean_ecnt", err_count_out, 0);
    chk("clean_bcnt", bit_count_out, 1000);
    chk("clean_pulses", err_pulses, 0);

    // Single error on the 100th bit of this phase
    send_n(99);
    chk("single_pre", err_out, 0);
    send(1'b1, 1'b0);
    chk("single_pulse", err_out, 1);
    send_n(1);
    chk("single_after", err_out, 0);
    send_n(29);
    chk("single_ecnt", err_count_out, 1);
    chk("single_pulses", err_pulses, 1);
    chk("single_locked", locked_out, 1);
    chk("single_bcnt", bit_count_out, 1130);

    // Four flips in one window (window starts at locked bit 1152)
    send_n(22);
    step(1'b0, 1'b0, 1'b1);
    chk("clr_ecnt", err_count_out, 0);
    chk("clr_bcnt", bit_count_out, 0);
    chk("clr_locked", locked_out, 1);
    send(1'b1, 1'b0); send_n(4);
    send(1'b1, 1'b0); send_n(4);
    send(1'b1, 1'b0); send_n(4);
    chk("loss_3rd", locked_out, 1);
    send(1'b1, 1'b0);
    chk("loss_4th", locked_out, 0);
    chk("loss_ecnt", err_count_out, 4);
    chk("loss_bcnt", bit_count_out, 16);
    send_n(15);
    chk("relock_15", locked_out, 0);
    send_n(1);
    chk("relock_16", locked_out, 1);
    chk("hunt_nocount", bit_count_out, 16);

    // 2 + 2 flips straddling a window boundary
    step(1'b0, 1'b0, 1'b1);
    err_pulses = 0;
    send_n(62);
    send(1'b1, 1'b0); send(1'b1, 1'b0);
    send(1'b1, 1'b0); send(1'b1, 1'b0);
    chk("spread_locked", locked_out, 1);
    chk("spread_ecnt", err_count_out, 4);
    chk("spread_bcnt", bit_count_out, 66);
    chk("spread_pulses", err_pulses, 4);

    // Fourth flip on the last bit of a window still drops lock
    send_n(122);
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    chk("edge_3rd", locked_out, 1);
    send(1'b1, 1'b0);
    chk("edge_4th", locked_out, 0);
    chk("edge_ecnt", err_count_out, 8);
    chk("edge_bcnt", bit_count_out, 192);

    // All-zero seed is rejected, then a real stream locks
    repeat (16) step(1'b1, 1'b0, 1'b0);
    chk("zero_seed", locked_out, 0);
    send_n(15);
    chk("zero_relock15", locked_out, 0);
    send_n(1);
    chk("zero_relock16", locked_out, 1);
    chk("zero_ecnt", err_count_out, 8);

    // Gaps: only valid cycles count, invalid bits are ignored
    step(1'b0, 1'b0, 1'b1);
    err_pulses = 0;
    repeat (4) begin
      send_n(1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      send_n(1);
    end
    chk("gap_bcnt", bit_count_out, 8);
    chk("gap_ecnt", err_count_out, 0);
    chk("gap_pulses", err_pulses, 0);

    // Clear coinciding with a mismatch wins on the totals only
    send(1'b1, 1'b1);
    chk("clrmis_err", err_out, 1);
    chk("clrmis_ecnt", err_count_out, 0);
    chk("clrmis_bcnt", bit_count_out, 0);
    send_n(1);
    chk("clrmis_bcnt1", bit_count_out, 1);
    send(1'b1, 1'b0);
    chk("post_ecnt", err_count_out, 1);
    chk("post_err", err_out, 1);

    // Asynchronous reset between edges
    rst_in = 1'b0;
    #1;
    chk("arst_locked", locked_out, 0);
    chk("arst_err", err_out, 0);
    chk("arst_ecnt", err_count_out, 0);
    chk("arst_bcnt", bit_count_out, 0);
    #2;
    rst_in = 1'b1;
    send_n(15);
    chk("arst_relock15", locked_out, 0);
    send_n(1);
    chk("arst_relock16", locked_out, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
